// File: rtl/cnt_cmd_sequencer.sv
// Command sequencer driving a 4-bit up/down counter: LOAD / UP N / DOWN N / HOLD N, with overflow tally.
// Optional CNT_CMD_SEQUENCER_CHECK_EN adds a shadow model of the counter and a sticky chk_err output.
module cnt_cmd_sequencer #(
  parameter int unsigned STEP_W = 8,
  parameter int unsigned OVF_W  = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              Enable,
  output logic              Load,
  output logic              Count,
  output logic [3:0]        Data_in,
  input  logic              C_out,
  input  logic [3:0]        A_count,
  output logic              busy,
  output logic              done,
`ifdef CNT_CMD_SEQUENCER_CHECK_EN
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              chk_err
`else
  output logic [OVF_W-1:0]  ovf_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_t;

  state_t            state, state_n;
  op_t               op;
  logic [STEP_W-1:0] steps_q, steps_n;
  logic              en_n, ld_n, cnt_n, accept;
  logic [3:0]        din_n;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state == S_IDLE);

  always_comb begin
    state_n = state;
    steps_n = steps_q;
    en_n    = Enable;
    ld_n    = Load;
    cnt_n   = Count;
    din_n   = Data_in;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (op == OP_LOAD) begin
            state_n = S_LOAD;
            en_n    = 1'b1;
            ld_n    = 1'b1;
            din_n   = cmd_data;
          end else if (cmd_steps == '0) begin
            state_n = S_DONE;
            en_n    = 1'b0;
          end else begin
            state_n = S_RUN;
            steps_n = cmd_steps;
            en_n    = (op != OP_HOLD);
            ld_n    = 1'b0;
            cnt_n   = (op == OP_UP);
          end
        end
      end
      S_LOAD: begin
        state_n = S_DONE;
        en_n    = 1'b0;
        ld_n    = 1'b0;
      end
      S_RUN: begin
        // Enable stays asserted through the edge that leaves RUN: N sampled enables.
        steps_n = steps_q - STEP_W'(1);
        if (steps_q == STEP_W'(1)) begin
          state_n = S_DONE;
          en_n    = 1'b0;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      steps_q <= '0;
      Enable  <= 1'b0;
      Load    <= 1'b0;
      Count   <= 1'b0;
      Data_in <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      state   <= state_n;
      steps_q <= steps_n;
      Enable  <= en_n;
      Load    <= ld_n;
      Count   <= cnt_n;
      Data_in <= din_n;
      busy    <= (state_n != S_IDLE);
      done    <= (state_n == S_DONE);
      // LOAD acceptance wins over a coincident carry.
      if (accept && op == OP_LOAD)
        ovf_cnt <= '0;
      else if (C_out && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

`ifdef CNT_CMD_SEQUENCER_CHECK_EN
  logic [3:0] shadow;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      chk_err <= 1'b0;
    end else begin
      if (accept) begin
        case (op)
          OP_LOAD: shadow <= cmd_data;
          OP_UP:   shadow <= shadow + cmd_steps[3:0];
          OP_DOWN: shadow <= shadow - cmd_steps[3:0];
          default: shadow <= shadow;
        endcase
      end
      if (state == S_DONE && A_count != shadow)
        chk_err <= 1'b1;
    end
  end
`else
  logic unused_a_count;
  assign unused_a_count = ^A_count;
`endif

endmodule

// File: doc/cnt_cmd_sequencer.md
Name: cnt_cmd_sequencer

Overview:
- Command-driven controller that sits directly upstream of the 4-bit up/down binary counter with parallel load, and is the sole driver of the counter's control pins (Enable, Load, Count, Data_in).
- Accepts one command at a time over a valid/ready handshake: load, count up N, count down N, or hold N.
- Watches the counter's carry output and keeps a saturating overflow tally.

Parameters:
- STEP_W, 8, width of the step-count field; up to 2^STEP_W-1 steps per command.
- OVF_W, 4, width of the saturating overflow counter.

Ports:
- CLK  input  1  clock, positive-edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
- cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- cmd_data  input  4  load value, used only by LOAD.
- cmd_steps  input  STEP_W  step count for UP/DOWN/HOLD; ignored for LOAD.
- Enable  output  1  to counter Enable.
- Load  output  1  to counter Load.
- Count  output  1  to counter Count; 1 = up, 0 = down.
- Data_in  output  4  to counter Data_in.
- C_out  input  1  carry from counter.
- A_count  input  4  counter value; used only by the optional feature.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at command completion.
- ovf_cnt  output  OVF_W  saturating count of observed C_out pulses.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; Enable=0, Load=0, Count=0, Data_in=0, busy=0, done=0, ovf_cnt=0, step counter=0. cmd_ready=1 after reset releases.
- All outputs are registered, and cmd_ready is a decode of state.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: a command is accepted on an edge where cmd_valid&cmd_ready=1. Its fields are latched, and the next state is chosen as follows.
  - LOAD: go to LOAD, driving Enable=1, Load=1, Data_in=cmd_data.
  - UP/DOWN with steps>0: go to RUN, driving Enable=1, Load=0, Count=(op==UP).
  - HOLD with steps>0: go to RUN, driving Enable=0.
  - Any of UP/DOWN/HOLD with steps=0: go straight to DONE; no Enable cycle is issued.
- LOAD: lasts exactly 1 cycle, so the counter samples Load once. Next state is DONE, with Enable=0 and Load=0.
- RUN: control outputs stay held for exactly N cycles. The remaining-step counter decrements each cycle, and when it reaches 1 the next state is DONE with Enable=0.
  - UP/DOWN therefore give exactly N counter enables.
  - HOLD gives N idle cycles.
- DONE: done=1 for 1 cycle, then IDLE. In the DONE cycle, A_count already reflects the full command.
- Latency:
  - LOAD: accept edge to done = 2 cycles.
  - UP/DOWN/HOLD with N>0: N+1 cycles.
  - N=0: 1 cycle.
- Back-to-back: a new command can be accepted in the cycle after done, i.e. on return to IDLE.
- cmd_* are ignored while busy; cmd_valid held high is not consumed until IDLE.
- ovf_cnt:
  - Increments on every cycle C_out=1 and saturates at 2^OVF_W-1.
  - Cleared to 0 on acceptance of a LOAD command. A C_out pulse on that same edge is dropped.
  - Wrap example: UP from 4'hF produces a C_out pulse one cycle after the wrapping edge, which may land in DONE; it is still counted.
- DOWN never produces a carry; underflow 0→F is not tallied.
- Reset asserted mid-command: immediate abort to the reset values above. No done pulse is generated, and the command is lost.

Optional Feature:
- Macro: CNT_CMD_SEQUENCER_CHECK_EN.
- When defined:
  - Adds output chk_err (1 bit, reset 0).
  - A 4-bit shadow register tracks the expected counter value:
    - set to cmd_data on LOAD;
    - +N mod 16 on UP;
    - -N mod 16 on DOWN;
    - unchanged on HOLD.
  - In the DONE cycle, if A_count != shadow, chk_err is set sticky; only reset clears it.
- When undefined: no chk_err port, no shadow register, and A_count is unused.

Test Plan:
- Reset, then LOAD data=4'hA -> Enable=Load=1 for exactly 1 cycle with Data_in=A; done 2 cycles after accept; A_count=A; ovf_cnt=0.
- LOAD 4'hD, then UP steps=5 -> Enable=1, Count=1 for exactly 5 cycles; A_count=2 at done; ovf_cnt=1 (C_out counted even if it lands in DONE).
- LOAD 4'h3, then DOWN steps=4 -> 4 enables with Count=0; A_count=F; ovf_cnt unchanged at 0.
- UP steps=0 and HOLD steps=3 -> for steps=0, done on the cycle after accept with no Enable; for HOLD, Enable=0 throughout and done after 4 cycles; A_count unchanged.
- Six consecutive UP steps=16 from 0 with OVF_W=2 -> ovf_cnt saturates at 3; a following LOAD clears it to 0; cmd_valid held high during busy never causes a second accept.
- reset pulsed low mid-RUN of UP steps=200 -> all outputs return to reset values asynchronously; no done pulse; with CNT_CMD_SEQUENCER_CHECK_EN defined, forcing A_count wrong at DONE sets chk_err=1.
